exception_ctrl: RTL and testbench
=================================

# exception_ctrl

Exception and interrupt sequencer for the single-cycle LEGv8 core. It sits beside `fetch` and is the only driver of its `EProc_F` and `EVAddr_F` inputs. It redirects the PC to the exception vector on an invalid opcode or an external interrupt. It records the return address and cause, and returns to the interrupted code on `ERET`.

## Interface

**Parameters**
- `N`, 64: address width.
- `VECTOR_ADDR`, 64'hD8: exception vector.
- `FATAL_ADDR`, 64'h1F0: nested-fault trap address.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: clock, rising edge active.
- `reset`, in, 1: asynchronous, active-low reset.
- `PC_F`, in, N: PC of the instruction executing this cycle (the `imem_addr_F` of `fetch`).
- `ExcInvOp_D`, in, 1: decode flags the current instruction as an invalid opcode.
- `ERet_D`, in, 1: decode flags the current instruction as `ERET`.
- `ExtIRQ`, in, 1: external interrupt request; asynchronous, level.
- `EProc_F`, out, 1: redirect request to `fetch`.
- `EVAddr_F`, out, N: redirect target.
- `ERR_o`, out, N: exception return register.
- `ESR_o`, out, 4: exception syndrome, one-hot.
- `InHandler_o`, out, 1: state is HANDLER.
- `Fatal_o`, out, 1: state is FATAL.

## Operation

**States:** RUN, HANDLER, FATAL.

**ESR codes:** IRQ = 4'b0001, INVOP = 4'b0010, BADERET = 4'b0100, NESTED = 4'b1000.

**IRQ path**
- `ExtIRQ` passes through a 2-flop synchronizer.
- A rising edge of the synchronized signal sets `irq_pend`.
- `irq_pend` clears only when the IRQ is taken.

**RUN.** Priority, evaluated every cycle:
1. If `ExcInvOp_D`: assert `EProc_F` with `EVAddr_F` = `VECTOR_ADDR`. At the clock edge, `ERR` <= `PC_F` and `ESR` <= INVOP. Next state HANDLER.
2. Else if `ERet_D`: same as case 1, but `ESR` <= BADERET.
3. Else if `irq_pend`: same redirect. `ERR` <= `PC_F`+4, `ESR` <= IRQ, `irq_pend` cleared. Next state HANDLER.
4. Else `EProc_F` = 0.

**HANDLER.** Interrupts are masked. A new IRQ edge still sets `irq_pend`.
1. If `ExcInvOp_D` (wins over `ERet_D`): `EProc_F` = 1, `EVAddr_F` = `FATAL_ADDR`, `ESR` <= NESTED, `ERR` unchanged. Next state FATAL.
2. Else if `ERet_D`: `EProc_F` = 1, `EVAddr_F` = `ERR`. Next state RUN.

**FATAL.** `EProc_F` = 1 and `EVAddr_F` = `FATAL_ADDR` every cycle. Only reset exits this state.

**General rules**
- When `EProc_F` = 0, `EVAddr_F` = `VECTOR_ADDR`.
- This block never suppresses register-file or memory writes of the current instruction. Decode is responsible for squashing invalid opcodes.
- All address arithmetic is N-bit and wraps modulo 2^N. `PC_F` = 2^N−4 gives `ERR` = 0.

## Timing

- `EProc_F` and `EVAddr_F` are combinational from the state, `ERR`, `irq_pend`, `ExcInvOp_D` and `ERet_D`. This gives zero-cycle redirect: `fetch` loads the target at the next rising edge.
- `ERR`, `ESR`, the state and `irq_pend` update on the rising edge that ends the redirect cycle.

**IRQ latency**
- `ExtIRQ` rises before edge k.
- `irq_pend` is high after edge k+2.
- `EProc_F` is high in the cycle after edge k+2, if in RUN.
- `ERR` is captured at edge k+3.
- `ExtIRQ` held high produces exactly one IRQ. It must fall and rise again for another.

**Reset.** While `reset` is low, asynchronously:
- state = RUN
- `ERR` = 0, `ESR` = 0
- `irq_pend` = 0, synchronizer flops = 0
- `EProc_F` is forced to 0.

The same values apply on reset mid-handler or in FATAL. There is no return to the interrupted code.

**Simultaneous events**
- `ERet_D` together with a pending IRQ in HANDLER: the return is taken first. The IRQ is taken on the first RUN cycle, with `ERR` = returned PC+4, so one instruction executes in between.
- An IRQ edge arriving in the same cycle the IRQ is being taken is kept pending.

## Structure

- **Package `exc_pkg`:** state enum (RUN, HANDLER, FATAL), ESR code constants, default `VECTOR_ADDR` and `FATAL_ADDR`.
- **Sub-module `irq_sync`:** 2-flop synchronizer plus rising-edge detect. Output is a 1-cycle pulse; reset is asynchronous, active-low.
- **Top-level `exception_ctrl`:** state register, `ERR`/`ESR`/`irq_pend` registers, redirect mux.

## Test plan

1. **Reset.** Assert `reset` = 0 mid-HANDLER → `EProc_F` = 0, `ERR_o` = 0, `ESR_o` = 0, `InHandler_o` = 0 immediately, without waiting for a clock.
2. **Invalid opcode.** `PC_F` = 64'h40, `ExcInvOp_D` for 1 cycle → `EProc_F` = 1 and `EVAddr_F` = 64'hD8 that cycle. Next cycle `ERR_o` = 64'h40, `ESR_o` = 4'b0010, `InHandler_o` = 1.
3. **IRQ.** Raise `ExtIRQ` before edge k, with `PC_F` = 64'h100 in the cycle after edge k+2 → `EProc_F` = 1 in that cycle. Then `ERR_o` = 64'h104, `ESR_o` = 4'b0001. Holding `ExtIRQ` high afterwards produces no second IRQ.
4. **ERET.** In HANDLER with `ERR_o` = 64'h104, `ERet_D` = 1 → `EVAddr_F` = 64'h104 and `EProc_F` = 1. Next cycle state is RUN.
5. **Nested fault.** In HANDLER, `ExcInvOp_D` and `ERet_D` both high → `EVAddr_F` = 64'h1F0, `Fatal_o` = 1, `ERR_o` unchanged. `EProc_F` stays 1 for 5 further cycles with no other inputs.
6. **Pending IRQ during return.** IRQ edge while in HANDLER, then `ERET` to 64'h200 → exactly one RUN cycle at `PC_F` = 64'h200. That cycle redirects to 64'hD8, and afterwards `ERR_o` = 64'h204.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception/interrupt sequencer.
// Holds the state encoding, one-hot syndrome codes and default vector addresses.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_FATAL   = 2'd2
    } exc_state_t;

    localparam logic [3:0] ESR_IRQ     = 4'b0001;
    localparam logic [3:0] ESR_INVOP   = 4'b0010;
    localparam logic [3:0] ESR_BADERET = 4'b0100;
    localparam logic [3:0] ESR_NESTED  = 4'b1000;

    localparam logic [63:0] DEF_VECTOR_ADDR = 64'hD8;
    localparam logic [63:0] DEF_FATAL_ADDR  = 64'h1F0;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt line,
// followed by a rising-edge detector that emits a one-cycle pulse.
module irq_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_irq,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: redirects fetch to the vector on invalid opcode
// or IRQ, records return address and syndrome, and returns on ERET.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int            N           = 64,
    parameter logic [N-1:0]  VECTOR_ADDR = DEF_VECTOR_ADDR[N-1:0],
    parameter logic [N-1:0]  FATAL_ADDR  = DEF_FATAL_ADDR[N-1:0]
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PC_F,
    input  logic         ExcInvOp_D,
    input  logic         ERet_D,
    input  logic         ExtIRQ,
    output logic         EProc_F,
    output logic [N-1:0] EVAddr_F,
    output logic [N-1:0] ERR_o,
    output logic [3:0]   ESR_o,
    output logic         InHandler_o,
    output logic         Fatal_o
);

    exc_state_t   r_state;
    exc_state_t   w_state_next;
    logic [N-1:0] r_err;
    logic [N-1:0] w_err_next;
    logic [3:0]   r_esr;
    logic [3:0]   w_esr_next;
    logic         r_irq_pend;
    logic         w_take_irq;
    logic         w_irq_pulse;
    logic         w_eproc;
    logic [N-1:0] w_evaddr;
    logic [N-1:0] w_pc_plus4;

    irq_sync u_irq_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_irq   (ExtIRQ),
        .o_pulse (w_irq_pulse)
    );

    assign w_pc_plus4 = PC_F + {{(N-3){1'b0}}, 3'd4};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_err      <= '0;
            r_esr      <= '0;
            r_irq_pend <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_err      <= w_err_next;
            r_esr      <= w_esr_next;
            // A new edge in the same cycle as the take keeps the request pending.
            r_irq_pend <= (r_irq_pend & ~w_take_irq) | w_irq_pulse;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        w_esr_next   = r_esr;
        w_take_irq   = 1'b0;
        w_eproc      = 1'b0;
        w_evaddr     = VECTOR_ADDR;
        unique case (r_state)
            ST_RUN: begin
                if (ExcInvOp_D) begin
                    w_eproc      = 1'b1;
                    w_err_next   = PC_F;
                    w_esr_next   = ESR_INVOP;
                    w_state_next = ST_HANDLER;
                end else if (ERet_D) begin
                    w_eproc      = 1'b1;
                    w_err_next   = PC_F;
                    w_esr_next   = ESR_BADERET;
                    w_state_next = ST_HANDLER;
                end else if (r_irq_pend) begin
                    // The interrupted instruction completes, so return past it.
                    w_eproc      = 1'b1;
                    w_err_next   = w_pc_plus4;
                    w_esr_next   = ESR_IRQ;
                    w_take_irq   = 1'b1;
                    w_state_next = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (ExcInvOp_D) begin
                    w_eproc      = 1'b1;
                    w_evaddr     = FATAL_ADDR;
                    w_esr_next   = ESR_NESTED;
                    w_state_next = ST_FATAL;
                end else if (ERet_D) begin
                    w_eproc      = 1'b1;
                    w_evaddr     = r_err;
                    w_state_next = ST_RUN;
                end
            end
            ST_FATAL: begin
                w_eproc  = 1'b1;
                w_evaddr = FATAL_ADDR;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Reset must silence the redirect even while decode flags are still high.
    assign EProc_F     = w_eproc & reset;
    assign EVAddr_F    = EProc_F ? w_evaddr : VECTOR_ADDR;
    assign ERR_o       = r_err;
    assign ESR_o       = r_esr;
    assign InHandler_o = (r_state == ST_HANDLER);
    assign Fatal_o     = (r_state == ST_FATAL);

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_exception_ctrl;

    localparam int N = 64;
    typedef logic [1+N+N+4+1+1-1:0] exp_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] PC_F;
    logic         ExcInvOp_D;
    logic         ERet_D;
    logic         ExtIRQ;
    logic         EProc_F;
    logic [N-1:0] EVAddr_F;
    logic [N-1:0] ERR_o;
    logic [3:0]   ESR_o;
    logic         InHandler_o;
    logic         Fatal_o;

    exp_t  exp_q[$];
    string name_q[$];
    int    total;
    int    bad;

    exception_ctrl #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .PC_F        (PC_F),
        .ExcInvOp_D  (ExcInvOp_D),
        .ERet_D      (ERet_D),
        .ExtIRQ      (ExtIRQ),
        .EProc_F     (EProc_F),
        .EVAddr_F    (EVAddr_F),
        .ERR_o       (ERR_o),
        .ESR_o       (ESR_o),
        .InHandler_o (InHandler_o),
        .Fatal_o     (Fatal_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic ep, input logic [N-1:0] va,
                       input logic [N-1:0] err, input logic [3:0] esr,
                       input logic inh, input logic fat);
        exp_q.push_back({ep, va, err, esr, inh, fat});
        name_q.push_back(nm);
    endtask

    task automatic drive(input logic [N-1:0] pc, input logic inv, input logic eret);
        PC_F       = pc;
        ExcInvOp_D = inv;
        ERet_D     = eret;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t  e;
        exp_t  g;
        string nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {EProc_F, EVAddr_F, ERR_o, ESR_o, InHandler_o, Fatal_o};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s: got eproc=%0b evaddr=%h err=%h esr=%b inh=%0b fatal=%0b, want eproc=%0b evaddr=%h err=%h esr=%b inh=%0b fatal=%0b",
                         nm, g[134], g[133:70], g[69:6], g[5:2], g[1], g[0],
                         e[134], e[133:70], e[69:6], e[5:2], e[1], e[0]);
            end
        end
    end

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        ExtIRQ = 1'b0;
        drive(64'h0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_init", 0, 64'hD8, 64'h0, 4'b0000, 0, 0);
        step(); reset = 1'b1;
        chk("run_idle", 0, 64'hD8, 64'h0, 4'b0000, 0, 0);

        // invalid opcode, then ERET back
        step(); drive(64'h40, 1'b1, 1'b0);
        chk("invop_redirect", 1, 64'hD8, 64'h0, 4'b0000, 0, 0);
        step(); drive(64'hD8, 1'b0, 1'b0);
        chk("invop_capture", 0, 64'hD8, 64'h40, 4'b0010, 1, 0);
        step(); drive(64'hDC, 1'b0, 1'b1);
        chk("eret_target", 1, 64'h40, 64'h40, 4'b0010, 1, 0);
        step(); drive(64'h40, 1'b0, 1'b0);
        chk("eret_run", 0, 64'hD8, 64'h40, 4'b0010, 0, 0);

        // ERET outside a handler
        step(); drive(64'h48, 1'b0, 1'b1);
        chk("bad_eret_redirect", 1, 64'hD8, 64'h40, 4'b0010, 0, 0);
        step(); drive(64'hD8, 1'b0, 1'b0);
        chk("bad_eret_capture", 0, 64'hD8, 64'h48, 4'b0100, 1, 0);
        step(); drive(64'hDC, 1'b0, 1'b1);
        chk("bad_eret_return", 1, 64'h48, 64'h48, 4'b0100, 1, 0);
        step(); drive(64'h48, 1'b0, 1'b0);
        chk("after_return", 0, 64'hD8, 64'h48, 4'b0100, 0, 0);

        // IRQ raised before edge k, redirect in cycle after k+2
        step(); drive(64'h4C, 1'b0, 1'b0); ExtIRQ = 1'b1;
        chk("irq_wait", 0, 64'hD8, 64'h48, 4'b0100, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(); drive(64'h50 + 64'(4 * i), 1'b0, 1'b0);
            chk("irq_wait", 0, 64'hD8, 64'h48, 4'b0100, 0, 0);
        end
        step(); drive(64'h100, 1'b0, 1'b0);
        chk("irq_redirect", 1, 64'hD8, 64'h48, 4'b0100, 0, 0);
        step(); drive(64'hD8, 1'b0, 1'b0);
        chk("irq_capture", 0, 64'hD8, 64'h104, 4'b0001, 1, 0);
        step(); drive(64'hDC, 1'b0, 1'b1);
        chk("irq_eret_target", 1, 64'h104, 64'h104, 4'b0001, 1, 0);
        step(); drive(64'h104, 1'b0, 1'b0);
        chk("irq_eret_run", 0, 64'hD8, 64'h104, 4'b0001, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(); drive(64'h108 + 64'(4 * i), 1'b0, 1'b0);
            chk("irq_held_no_retrigger", 0, 64'hD8, 64'h104, 4'b0001, 0, 0);
        end

        // second IRQ at the top of the address space wraps ERR to 0
        step(); ExtIRQ = 1'b0;
        chk("irq_low", 0, 64'hD8, 64'h104, 4'b0001, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("irq_low", 0, 64'hD8, 64'h104, 4'b0001, 0, 0);
        end
        step(); ExtIRQ = 1'b1;
        chk("wrap_wait", 0, 64'hD8, 64'h104, 4'b0001, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wrap_wait", 0, 64'hD8, 64'h104, 4'b0001, 0, 0);
        end
        step(); drive(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        chk("wrap_redirect", 1, 64'hD8, 64'h104, 4'b0001, 0, 0);
        step(); drive(64'hD8, 1'b0, 1'b0);
        chk("wrap_capture", 0, 64'hD8, 64'h0, 4'b0001, 1, 0);
        step(); drive(64'hDC, 1'b0, 1'b1);
        chk("wrap_eret", 1, 64'h0, 64'h0, 4'b0001, 1, 0);
        step(); drive(64'h0, 1'b0, 1'b0);
        chk("wrap_run", 0, 64'hD8, 64'h0, 4'b0001, 0, 0);

        // IRQ edge inside handler, taken right after ERET with one RUN cycle
        step(); ExtIRQ = 1'b0; drive(64'h200, 1'b1, 1'b0);
        chk("pend_invop", 1, 64'hD8, 64'h0, 4'b0001, 0, 0);
        step(); drive(64'hD8, 1'b0, 1'b0);
        chk("pend_handler", 0, 64'hD8, 64'h200, 4'b0010, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pend_handler", 0, 64'hD8, 64'h200, 4'b0010, 1, 0);
        end
        step(); ExtIRQ = 1'b1;
        chk("pend_masked", 0, 64'hD8, 64'h200, 4'b0010, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pend_masked", 0, 64'hD8, 64'h200, 4'b0010, 1, 0);
        end
        step(); drive(64'hDC, 1'b0, 1'b1);
        chk("pend_eret", 1, 64'h200, 64'h200, 4'b0010, 1, 0);
        step(); drive(64'h200, 1'b0, 1'b0);
        chk("pend_one_run_cycle", 1, 64'hD8, 64'h200, 4'b0010, 0, 0);
        step(); drive(64'hD8, 1'b0, 1'b0);
        chk("pend_irq_capture", 0, 64'hD8, 64'h204, 4'b0001, 1, 0);

        // asynchronous reset mid-handler, with decode flag still high
        step(); reset = 1'b0; ExtIRQ = 1'b0; drive(64'hDC, 1'b1, 1'b0);
        chk("reset_mid_handler", 0, 64'hD8, 64'h0, 4'b0000, 0, 0);
        step(); reset = 1'b1; drive(64'h0, 1'b0, 1'b0);
        chk("reset_release", 0, 64'hD8, 64'h0, 4'b0000, 0, 0);

        // nested fault: both flags high in handler, then FATAL holds
        step(); drive(64'h300, 1'b1, 1'b0);
        chk("nest_invop", 1, 64'hD8, 64'h0, 4'b0000, 0, 0);
        step(); drive(64'hD8, 1'b0, 1'b0);
        chk("nest_handler", 0, 64'hD8, 64'h300, 4'b0010, 1, 0);
        step(); drive(64'hDC, 1'b1, 1'b1);
        chk("nest_fault", 1, 64'h1F0, 64'h300, 4'b0010, 1, 0);
        step(); drive(64'h1F0, 1'b0, 1'b0);
        chk("fatal_hold", 1, 64'h1F0, 64'h300, 4'b1000, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fatal_hold", 1, 64'h1F0, 64'h300, 4'b1000, 0, 1);
        end
        step(); drive(64'h1F4, 1'b0, 1'b1);
        chk("fatal_ignores_eret", 1, 64'h1F0, 64'h300, 4'b1000, 0, 1);
        step(); reset = 1'b0;
        chk("reset_in_fatal", 0, 64'hD8, 64'h0, 4'b0000, 0, 0);
        step(); reset = 1'b1; drive(64'h0, 1'b0, 1'b0);
        chk("fatal_reset_run", 0, 64'hD8, 64'h0, 4'b0000, 0, 0);

        step();
        step();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
